// File: rtl/dcm_spi_pkg.sv
// Shared types and register-map constants for the
// dcmctrl SPI master.
package dcm_spi_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 6;
  localparam int CMD_ADDR_LSB  = 0;

  // Per-channel register window; write record is speed
  // then pos[23:0] MSB first, read record is flags then pos.
  localparam int REG_CH_STRIDE = 64;
  localparam int REG_SPEED_OFS = 0;
  localparam int REG_FLAGS_OFS = 0;
  localparam int REG_POS_OFS   = 1;
  localparam int REG_POS_BYTES = 3;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  function automatic cmd_t mk_cmd(
    input logic       wr,
    input logic [6:0] addr
  );
    return '{wr: wr, addr: addr};
  endfunction

endpackage

// File: rtl/dcm_spi_shifter.sv
// 8-bit MSB-first shift register: parallel load,
// shift-in at the LSB on each MISO sample.
module dcm_spi_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       shift,
  input  logic       sin,
  output logic [7:0] q,
  output logic       msb
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[6:0], sin};
    end
  end

  assign msb = q[7];

endmodule

// File: rtl/dcm_spi_master.sv
// SPI mode-3 master issuing command + N data byte
// frames to the dcmctrl register file.
module dcm_spi_master
  import dcm_spi_pkg::*;
#(
  parameter int CLKDIV   = 5,
  parameter int SS_SETUP = 5,
  parameter int SS_HOLD  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       xfer_start,
  input  logic [7:0] xfer_cmd,
  input  logic [7:0] xfer_len,
  output logic       xfer_busy,
  output logic       xfer_done,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_ss,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int M1 = (CLKDIV > SS_SETUP) ? CLKDIV : SS_SETUP;
  localparam int MX = (M1 > SS_HOLD) ? M1 : SS_HOLD;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] DIV_LD  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] SET_LD  = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(SS_HOLD - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    byte_cnt;
  cmd_t          cmd_q;
  logic          data_ph;
  logic          rx_pend;

  logic          sh_load;
  logic          sh_shift;
  logic [7:0]    sh_din;
  logic [7:0]    sh_q;
  logic          sh_msb;

  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = cmd_q;
    unique case (1'b1)
      state == S_SETUP: sh_load = (cnt == '0);
      state == S_LOAD: begin
        sh_load = tx_valid;
        sh_din  = tx_data;
      end
      state == S_LOW: sh_shift = (cnt == '0);
      default: ;
    endcase
  end

  dcm_spi_shifter u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .din   (sh_din),
    .shift (sh_shift),
    .sin   (spi_miso),
    .q     (sh_q),
    .msb   (sh_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      cmd_q     <= '0;
      data_ph   <= 1'b0;
      rx_pend   <= 1'b0;
      spi_ss    <= 1'b1;
      spi_clk   <= 1'b1;
      spi_mosi  <= 1'b0;
      xfer_busy <= 1'b0;
      xfer_done <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      xfer_done <= 1'b0;
      rx_valid  <= rx_pend;
      rx_pend   <= 1'b0;
      if (rx_pend) rx_data <= sh_q;
      unique case (state)
        S_IDLE: begin
          if (xfer_start) begin
            cmd_q     <= xfer_cmd;
            byte_cnt  <= xfer_len;
            bit_cnt   <= '0;
            data_ph   <= 1'b0;
            spi_ss    <= 1'b0;
            xfer_busy <= 1'b1;
            cnt       <= SET_LD;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            spi_mosi <= cmd_q.wr;
            spi_clk  <= 1'b0;
            cnt      <= DIV_LD;
            state    <= S_LOW;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            tx_ready <= 1'b0;
            spi_mosi <= tx_data[7];
            spi_clk  <= 1'b0;
            data_ph  <= 1'b1;
            cnt      <= DIV_LD;
            state    <= S_LOW;
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            spi_clk <= 1'b1;
            rx_pend <= data_ph && (bit_cnt == 3'd7);
            cnt     <= DIV_LD;
            state   <= S_HIGH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              spi_clk  <= 1'b0;
              spi_mosi <= sh_msb;
              cnt      <= DIV_LD;
              state    <= S_LOW;
            end else if (byte_cnt != 8'd0) begin
              byte_cnt <= byte_cnt - 8'd1;
              tx_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              cnt   <= HOLD_LD;
              state <= S_HOLD;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            spi_ss <= 1'b1;
            cnt    <= HOLD_LD;
            state  <= S_GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            xfer_done <= 1'b1;
            xfer_busy <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_spi_master.sv
// Directed bench for dcm_spi_master with a mode-3
// slave model on the SPI pins.
module tb_dcm_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       xfer_start = 1'b0;
  logic [7:0] xfer_cmd = 8'h00;
  logic [7:0] xfer_len = 8'h00;
  logic       xfer_busy;
  logic       xfer_done;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_ss;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  always #5 clk = ~clk;

  dcm_spi_master dut (
    .clk        (clk),
    .reset      (reset),
    .xfer_start (xfer_start),
    .xfer_cmd   (xfer_cmd),
    .xfer_len   (xfer_len),
    .xfer_busy  (xfer_busy),
    .xfer_done  (xfer_done),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .spi_ss     (spi_ss),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_buf[8];
  logic [7:0] miso_buf[8];
  logic [7:0] cap[16];
  logic [7:0] rx_log[8];

  int cap_n = 0;
  int rise_n = 0;
  int sbit = 0;
  int mbit = 0;
  int mbyte = 0;
  logic [7:0] sh = 8'h00;
  logic p_ss = 1'b1;
  logic p_clk = 1'b1;

  int ss_low, t_rise, t_done, done_n;
  int rx_n, ready_seen, stall_bad, post_low;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode-3 slave: capture MOSI on rising, drive MISO on falling
  always @(negedge clk) begin
    if (p_ss && !spi_ss) begin
      cap_n = 0;
      rise_n = 0;
      sbit = 0;
      mbit = 0;
      mbyte = 0;
    end
    if (!spi_ss && !p_clk && spi_clk) begin
      rise_n++;
      sh = {sh[6:0], spi_mosi};
      sbit++;
      if (sbit == 8) begin
        if (cap_n < 16) cap[cap_n] = sh;
        cap_n++;
        sbit = 0;
      end
    end
    if (!spi_ss && p_clk && !spi_clk) begin
      spi_miso = miso_buf[mbyte[2:0]][3'(7 - mbit)];
      mbit++;
      if (mbit == 8) begin
        mbit = 0;
        mbyte++;
      end
    end
    p_ss = spi_ss;
    p_clk = spi_clk;
  end

  task automatic run_xfer(
    input logic [7:0] cmd,
    input int         len,
    input int         st_idx,
    input int         st_n,
    input bit         abort,
    input bit         ign
  );
    int idx, stl;
    bit hs, pss, aborted;
    ss_low = 0;
    t_rise = -1;
    t_done = -1;
    done_n = 0;
    rx_n = 0;
    ready_seen = 0;
    stall_bad = 0;
    post_low = 0;
    idx = 0;
    stl = st_n;
    hs = 0;
    pss = 1;
    aborted = 0;
    @(negedge clk);
    xfer_cmd = cmd;
    xfer_len = 8'(len);
    xfer_start = 1'b1;
    tx_valid = 1'b0;
    for (int k = 1; k < 3000 && t_done < 0; k++) begin
      @(negedge clk);
      xfer_start = 1'b0;
      if (ign && k == 50) begin
        xfer_start = 1'b1;
        xfer_cmd = 8'hFF;
        xfer_len = 8'd9;
      end
      if (hs) begin
        idx++;
        hs = 0;
      end
      if (tx_ready) ready_seen = 1;
      if (tx_ready && idx == st_idx && stl > 0) begin
        tx_valid = 1'b0;
        stl--;
        if (!(spi_clk && !spi_ss)) stall_bad++;
      end else begin
        tx_valid = (idx < len);
        tx_data = (idx < 8) ? tx_buf[idx[2:0]] : 8'h00;
      end
      if (tx_ready && tx_valid) hs = 1;
      if (!spi_ss) ss_low++;
      if (spi_ss && !pss && t_rise < 0) t_rise = k;
      pss = spi_ss;
      if (rx_valid && rx_n < 8) begin
        rx_log[rx_n] = rx_data;
        rx_n++;
      end
      if (xfer_done) begin
        done_n++;
        t_done = k;
      end
      if (abort && cap_n == 2 && sbit == 3) begin
        reset = 1'b0;
        #1;
        chk("rst_async",
            int'({spi_ss, spi_clk, xfer_busy, xfer_done, tx_ready}),
            'b11000);
        tx_valid = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (xfer_done) done_n++;
        end
        chk("rst_no_done", done_n, 0);
        chk("rst_held", int'({spi_ss, spi_clk, xfer_busy}), 'b110);
        reset = 1'b1;
        aborted = 1;
        break;
      end
    end
    tx_valid = 1'b0;
    if (!aborted) begin
      repeat (30) begin
        @(negedge clk);
        if (!spi_ss) post_low++;
        if (xfer_done) done_n++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tx_buf[i] = 8'h00;
      miso_buf[i] = 8'h00;
      rx_log[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_outs",
        int'({spi_ss, spi_clk, spi_mosi, xfer_busy,
              xfer_done, tx_ready, rx_valid}),
        'b1100000);
    chk("reset_rxdata", int'(rx_data), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    tx_buf[0] = 8'd100;
    tx_buf[1] = 8'd0;
    tx_buf[2] = 8'd0;
    tx_buf[3] = 8'd200;
    run_xfer(8'hC0, 4, -1, 0, 0, 0);
    chk("wr_nbytes", cap_n, 5);
    chk("wr_cmd", int'(cap[0]), 'hC0);
    chk("wr_data", int'({cap[1], cap[2], cap[3], cap[4]}), 32'h640000C8);
    chk("wr_ss_low", ss_low, 419);
    chk("wr_done_lat", t_done - t_rise, 10);
    chk("wr_total", t_done, 430);
    chk("wr_done_n", done_n, 1);
    chk("wr_rises", rise_n, 40);
    chk("wr_ready", ready_seen, 1);

    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    miso_buf[0] = 8'h5A;
    miso_buf[1] = 8'hA5;
    miso_buf[2] = 8'h01;
    miso_buf[3] = 8'h02;
    miso_buf[4] = 8'h03;
    run_xfer(8'h00, 4, -1, 0, 0, 0);
    chk("rd_cmd", int'(cap[0]), 0);
    chk("rd_rx_n", rx_n, 4);
    chk("rd_rx", int'({rx_log[0], rx_log[1], rx_log[2], rx_log[3]}),
        32'hA5010203);
    chk("rd_total", t_done, 430);
    chk("rd_rx_hold", int'(rx_data), 'h03);

    tx_buf[0] = 8'h11;
    tx_buf[1] = 8'h22;
    tx_buf[2] = 8'h33;
    run_xfer(8'h85, 3, 1, 37, 0, 0);
    chk("st_data", int'({cap[0], cap[1], cap[2], cap[3]}), 32'h85112233);
    chk("st_ss_low", ss_low, 375);
    chk("st_rises", rise_n, 32);
    chk("st_clk_ss", stall_bad, 0);
    chk("st_done_lat", t_done - t_rise, 10);

    run_xfer(8'h41, 0, -1, 0, 0, 0);
    chk("l0_rises", rise_n, 8);
    chk("l0_cmd", int'(cap[0]), 'h41);
    chk("l0_ready", ready_seen, 0);
    chk("l0_total", t_done, 106);
    chk("l0_done_n", done_n, 1);

    tx_buf[0] = 8'd100;
    tx_buf[1] = 8'd0;
    tx_buf[2] = 8'd0;
    tx_buf[3] = 8'd200;
    run_xfer(8'hC0, 4, -1, 0, 1, 0);
    tx_buf[0] = 8'hAB;
    tx_buf[1] = 8'hCD;
    run_xfer(8'h81, 2, -1, 0, 0, 0);
    chk("ar_data", int'({cap[0], cap[1], cap[2]}), 32'h0081ABCD);
    chk("ar_total", t_done, 268);
    chk("ar_done_n", done_n, 1);

    tx_buf[0] = 8'h12;
    tx_buf[1] = 8'h34;
    run_xfer(8'h82, 2, -1, 0, 0, 1);
    chk("ig_nbytes", cap_n, 3);
    chk("ig_data", int'({cap[0], cap[1], cap[2]}), 32'h00821234);
    chk("ig_total", t_done, 268);
    chk("ig_done_n", done_n, 1);
    chk("ig_no_restart", post_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
